// File: rtl/counter_display_pkg.sv
// rtl/counter_display_pkg.sv - shared state encoding and seven-segment glyphs for the counter display driver
package counter_display_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entries 10..15 cannot occur in valid BCD and stay dark
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/counter_display_driver_bin2bcd_seq.sv
// rtl/counter_display_driver_bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter
module bin2bcd_seq #(
    parameter int N      = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + N;
    localparam int CW = $clog2(N + 1);

    logic [SW-1:0] shreg;
    logic [SW-1:0] adj;
    logic [CW-1:0] iter;

    always_comb begin
        adj = shreg;
        for (int d = 0; d < DIGITS; d++) begin
            if (shreg[N+4*d +: 4] >= 4'd5)
                adj[N+4*d +: 4] = shreg[N+4*d +: 4] + 4'd3;
        end
    end

    assign busy = (iter != '0);
    // done flags the final iteration; the result lands in bcd on the same edge
    assign done = (iter == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            iter  <= '0;
            bcd   <= '0;
        end else if (start) begin
            shreg <= {{BW{1'b0}}, bin};
            iter  <= CW'(N);
        end else if (busy) begin
            shreg <= {adj[SW-2:0], 1'b0};
            iter  <= iter - CW'(1);
            if (done)
                bcd <= adj[SW-2 -: BW];
        end
    end

endmodule

// File: rtl/counter_display_driver.sv
// rtl/counter_display_driver.sv - glitch-filtered capture, BCD conversion and multiplexed seven-segment scan
module counter_display_driver
    import counter_display_pkg::*;
#(
    parameter int N           = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          cnt_in,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  valid_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned MAX_DISPLAY = 10**DIGITS - 1;

    logic [N-1:0]  s1, s2, s3, last_acc, pend_val, conv_bin;
    logic          accept, pending, conv_start, conv_busy, conv_done;
    state_t        state;

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [3:0]        nib;
    logic              zero_run;
    logic [DIGITS-1:0] upper_zero;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] an_next;

    // A value must survive two consecutive samples to count as settled
    assign accept     = (s2 == s3) && (s2 != last_acc);
    assign conv_start = (state != ST_CONV) && (accept || pending);
    assign conv_bin   = accept ? s2 : pend_val;
    assign valid_o    = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            last_acc <= '0;
            pend_val <= '0;
            pending  <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            s3 <= s2;
            if (accept)
                last_acc <= s2;
            case (state)
                ST_CONV: begin
                    if (accept) begin
                        pending  <= 1'b1;
                        pend_val <= s2;
                    end
                    if (conv_done)
                        state <= ST_DONE;
                end
                default: begin
                    // IDLE and DONE both launch directly; a fresh accept beats a stale pending value
                    pending <= 1'b0;
                    state   <= conv_start ? ST_CONV : ST_IDLE;
                end
            endcase
        end
    end

    bin2bcd_seq #(
        .N      (N),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd_o)
    );

    always_comb begin
        nib      = bcd_o[4*idx +: 4];
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (bcd_o[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_run;
        end
        seg_next = SEG_TABLE[nib];
        if ((BLANK_LZ != 0) && (idx != '0) && upper_zero[idx])
            seg_next = SEG_BLANK;
        an_next = ~(DIGITS'(1) << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
            seg_o <= SEG_TABLE[0];
            an_o  <= ~DIGITS'(1);
        end else begin
            seg_o <= seg_next;
            an_o  <= an_next;
            if (presc == PW'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    a_range: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (32'(s2) <= MAX_DISPLAY))
        else $error("counter value exceeds display range");

    a_conv_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_CONV) |-> conv_busy)
        else $error("converter idle while in CONV");

endmodule

// File: tb/tb_counter_display_driver.sv
// tb/tb_counter_display_driver.sv - directed self-checking bench for counter_display_driver
module tb_counter_display_driver;

    localparam int N           = 4;
    localparam int DIGITS      = 2;
    localparam int REFRESH_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic [7:0] bcd_o;
    logic       valid_o;
    logic [6:0] seg_o;
    logic [1:0] an_o;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    logic [7:0] pulse_vals[$];

    logic [7:0] dec_tab [0:15] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                   8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

    counter_display_driver #(
        .N           (N),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_LZ    (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_in  (cnt_in),
        .bcd_o   (bcd_o),
        .valid_o (valid_o),
        .seg_o   (seg_o),
        .an_o    (an_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            pulses <= pulses + 1;
            pulse_vals.push_back(bcd_o);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int p0;
        rst_n  = 1'b0;
        cnt_in = 4'd0;
        cycles(2);
        checks++; if (bcd_o !== 8'h00) begin failures++; $display("FAIL reset_bcd: got %h expected 00", bcd_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (an_o !== 2'b10) begin failures++; $display("FAIL reset_an: got %b expected 10", an_o); end
        checks++; if (seg_o !== 7'h40) begin failures++; $display("FAIL reset_seg: got %h expected 40", seg_o); end
        rst_n = 1'b1;
        p0 = pulses;
        cycles(20);
        checks++; if (pulses !== p0) begin failures++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", pulses - p0); end
        checks++; if (bcd_o !== 8'h00) begin failures++; $display("FAIL reset_bcd_hold: got %h expected 00", bcd_o); end
    endtask

    task automatic test_convert();
        int p0;
        p0 = pulses;
        cnt_in = 4'd13;
        cycles(7);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL conv_early: got valid %b expected 0", valid_o); end
        cycles(1);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL conv_latency: got valid %b expected 1", valid_o); end
        checks++; if (bcd_o !== 8'h13) begin failures++; $display("FAIL conv_bcd: got %h expected 13", bcd_o); end
        cycles(1);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL conv_one_cycle: got valid %b expected 0", valid_o); end
        checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL conv_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_scan();
        logic [1:0] cur;
        logic [6:0] exp_seg;
        int guard;
        int run;
        cycles(2);
        cur = an_o;
        guard = 0;
        while (an_o === cur && guard < 12) begin cycles(1); guard++; end
        checks++; if (guard >= 12) begin failures++; $display("FAIL scan_align: an_o stuck at %b expected toggle", cur); end
        for (int r = 0; r < 3; r++) begin
            cur = an_o;
            run = 0;
            while (an_o === cur && run < 12) begin
                exp_seg = (cur == 2'b10) ? 7'h30 : 7'h79;
                checks++;
                if (cur !== 2'b10 && cur !== 2'b01) begin failures++; $display("FAIL scan_an: got %b expected 10 or 01", cur); end
                else if (seg_o !== exp_seg) begin failures++; $display("FAIL scan_seg: got %h expected %h (an %b)", seg_o, exp_seg, cur); end
                cycles(1);
                run++;
            end
            checks++; if (run !== REFRESH_DIV) begin failures++; $display("FAIL scan_dwell: got %0d expected %0d", run, REFRESH_DIV); end
        end
    endtask

    task automatic test_glitch();
        int p0;
        logic [6:0] exp_seg;
        cnt_in = 4'd7;
        cycles(12);
        p0 = pulses;
        cnt_in = 4'd4;
        cycles(1);
        cnt_in = 4'd8;
        cycles(12);
        checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL glitch_pulses: got %0d expected 1", pulses - p0); end
        else begin
            checks++; if (pulse_vals[p0] !== 8'h08) begin failures++; $display("FAIL glitch_value: got %h expected 08", pulse_vals[p0]); end
        end
        checks++; if (bcd_o !== 8'h08) begin failures++; $display("FAIL glitch_bcd: got %h expected 08", bcd_o); end
        for (int i = 0; i < 10; i++) begin
            exp_seg = (an_o == 2'b01) ? 7'h7F : 7'h00;
            checks++;
            if (an_o !== 2'b10 && an_o !== 2'b01) begin failures++; $display("FAIL blank_an: got %b expected 10 or 01", an_o); end
            else if (seg_o !== exp_seg) begin failures++; $display("FAIL blank_seg: got %h expected %h (an %b)", seg_o, exp_seg, an_o); end
            cycles(1);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        cnt_in = 4'd5;
        cycles(4);
        cnt_in = 4'd9;
        cycles(1);
        cnt_in = 4'd15;
        cycles(16);
        checks++; if (pulses - p0 !== 2) begin failures++; $display("FAIL b2b_pulses: got %0d expected 2", pulses - p0); end
        else begin
            checks++; if (pulse_vals[p0] !== 8'h05) begin failures++; $display("FAIL b2b_first: got %h expected 05", pulse_vals[p0]); end
            checks++; if (pulse_vals[p0+1] !== 8'h15) begin failures++; $display("FAIL b2b_second: got %h expected 15", pulse_vals[p0+1]); end
        end
    endtask

    task automatic test_latest_wins();
        int p0;
        p0 = pulses;
        cnt_in = 4'd5;
        cycles(2);
        cnt_in = 4'd9;
        cycles(2);
        cnt_in = 4'd15;
        cycles(16);
        checks++; if (pulses - p0 !== 2) begin failures++; $display("FAIL latest_pulses: got %0d expected 2", pulses - p0); end
        else begin
            checks++; if (pulse_vals[p0] !== 8'h05) begin failures++; $display("FAIL latest_first: got %h expected 05", pulse_vals[p0]); end
            checks++; if (pulse_vals[p0+1] !== 8'h15) begin failures++; $display("FAIL latest_second: got %h expected 15", pulse_vals[p0+1]); end
        end
        checks++; if (bcd_o !== 8'h15) begin failures++; $display("FAIL latest_bcd: got %h expected 15", bcd_o); end
    endtask

    task automatic test_reset_mid_conv();
        int p0;
        cnt_in = 4'd12;
        cycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bcd_o !== 8'h00) begin failures++; $display("FAIL abort_bcd: got %h expected 00", bcd_o); end
        checks++; if (seg_o !== 7'h40) begin failures++; $display("FAIL abort_seg: got %h expected 40", seg_o); end
        checks++; if (an_o !== 2'b10) begin failures++; $display("FAIL abort_an: got %b expected 10", an_o); end
        cycles(2);
        p0 = pulses;
        rst_n = 1'b1;
        cycles(12);
        checks++; if (bcd_o !== 8'h12) begin failures++; $display("FAIL abort_rerun: got %h expected 12", bcd_o); end
        checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL abort_pulses: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_sweep();
        int p0;
        logic [3:0] prev;
        logic [3:0] v;
        rst_n  = 1'b0;
        cnt_in = 4'd0;
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        p0 = pulses;
        prev = 4'd0;
        for (int step = 1; step <= 30; step++) begin
            v = (step <= 15) ? 4'(step) : 4'(30 - step);
            // one-cycle ripple intermediate before the counter settles
            cnt_in = prev & v;
            cycles(1);
            cnt_in = v;
            cycles(12);
            checks++; if (bcd_o !== dec_tab[v]) begin failures++; $display("FAIL sweep_bcd: cnt %0d got %h expected %h", v, bcd_o, dec_tab[v]); end
            prev = v;
        end
        checks++; if (pulses - p0 !== 30) begin failures++; $display("FAIL sweep_pulses: got %0d expected 30", pulses - p0); end
        p0 = pulses;
        cycles(20);
        checks++; if (pulses !== p0) begin failures++; $display("FAIL sweep_idle: got %0d pulses expected 0", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_scan();
        test_glitch();
        test_back_to_back();
        test_latest_wins();
        test_reset_mid_conv();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_display_driver.md
Name: counter_display_driver

Overview:
Downstream consumer of the ripple up/down counter's `cnt` bus. It does four things:
- resynchronises the counter value and filters out ripple-settling glitches;
- converts the accepted binary value to BCD with a sequential shift-add-3 (double-dabble) engine;
- drives a time-multiplexed, active-low seven-segment display;
- presents the BCD value with a one-cycle update strobe for logging and checking.

Parameters:
- N, 4, width of the incoming counter value; must match the counter's N.
- DIGITS, 2, number of display digits; must satisfy 10^DIGITS > 2^N - 1.
- REFRESH_DIV, 50000, clk cycles each digit stays lit; minimum 2.
- BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cnt_in  input  N  counter value from the asynchronous counter; may glitch, unrelated to clk.
- bcd_o  output  4*DIGITS  last converted value, digit 0 in bits [3:0].
- valid_o  output  1  one-cycle pulse when bcd_o updates.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_o  output  DIGITS  digit enables, one-hot active-low.

Behaviour:
- Reset (async assert, sync release):
  - bcd_o = 0, valid_o = 0.
  - sync/filter registers = 0; last-accepted register = 0.
  - FSM = IDLE; pending flag = 0.
  - prescaler = 0, scan index = 0.
  - an_o = all ones except bit 0 low; seg_o = 7'b1000000 (glyph '0').
- Input capture:
  - 2-flop synchroniser s1 -> s2, plus history register s3 <= s2.
  - Accept condition: s2 == s3 AND s2 != last_accepted.
  - On accept, last_accepted <= s2.
  - A value that differs between consecutive samples is never accepted.
- FSM states IDLE, CONV, DONE:
  - IDLE: on accept, load shift register {BCD = 0, BIN = s2}, load iteration counter = N, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {BCD, BIN} left 1 and decrement the counter. When the counter reaches 0, go to DONE.
  - DONE: bcd_o <= BCD field, valid_o = 1 for exactly this cycle. Next state is CONV if pending is set (pending consumed), else IDLE.
- Overlap: an accept occurring in CONV or DONE stores the value in a 1-deep pending register and sets pending. A newer accept overwrites the older pending value (latest wins). Pending is loaded in DONE with no IDLE bubble.
- Latency: cnt_in stable from clock edge k gives valid_o high in the cycle following edge k+4+N; for N=4 that is 8 edges.
- Width rules:
  - BCD field is 4*DIGITS bits.
  - Sum of shift register and iteration count must not overflow.
  - Values at or above 10^DIGITS are excluded by the parameter constraint; add a simulation-time assertion for it.
- Display scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances modulo DIGITS (DIGITS-1 -> 0).
  - an_o low at the scan index only.
  - seg_o = glyph of bcd_o nibble[index], decoded combinationally from registered bcd_o, then registered.
  - Nibble values 10..15 (impossible) display all-off.
  - Blanking with BLANK_LZ=1: digit i > 0 is blanked (seg_o all ones, an_o still low) when nibbles i..DIGITS-1 are all zero.
- Reset mid-conversion: async abort to reset state; the display returns to '0' immediately.

Decomposition:
- Package `counter_display_pkg` holds:
  - FSM state typedef (IDLE/CONV/DONE);
  - the 16-entry seven-segment glyph constant table;
  - SEG_BLANK = 7'h7F.
- One natural sub-module, `bin2bcd_seq`: start, bin, busy, done, bcd; parameterised by N and DIGITS. It carries the double-dabble datapath and iteration counter.
- Capture/filter, pending logic and scan stay in the top.

Test Plan:
- Reset, then release with cnt_in=0 -> bcd_o=8'h00, valid_o never pulses, an_o=2'b10, seg_o=7'b1000000.
- cnt_in=4'd13, held steady -> after 8 edges valid_o pulses for 1 cycle, bcd_o=8'h13. With REFRESH_DIV=4 the scan shows '3' on digit 0 and '1' on digit 1, alternating every 4 cycles.
- Ripple glitch: cnt_in 7 -> 4 -> 8 with 4 lasting under 1 cycle (sampled once) -> only 8 is converted, bcd_o=8'h08, exactly one valid_o pulse; digit 1 blanked (seg_o=7'h7F while an_o=2'b01).
- Back-to-back changes: cnt_in=5, then 9 four cycles later, then 15 one cycle after that (all during CONV) -> two valid_o pulses only (first bcd_o=8'h05, then 8'h15 directly from pending); 9 is never reported.
- Assert rst_n low in mid-CONV for a value of 12 -> bcd_o=0 and seg_o=7'b1000000 asynchronously. After release with cnt_in still 12, the conversion reruns and bcd_o=8'h12.
- Sweep cnt_in 0..15 with the up/down counter from the neighbouring stage in the loop -> every bcd_o matches the decimal of cnt after settling; no valid_o pulse occurs without a value change.
